// File: rtl/mem_byte_bridge.sv
// Bridges core memory requests onto a byte-wide SRAM; ready rises 1+nbytes*(WAIT_STATES+1) cycles after accept (1 if misaligned).
// No backpressure beyond req_ready: the core holds the request until ready, then withdraws it (req_size=0) to free the bridge.
module mem_byte_bridge #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  output logic [31:0]       req_rdata,
  output logic              req_ready,
  output logic              busy,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_re,
  output logic              sram_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [31:0]       rdata_d;
  logic              ready_d, err_d, re_d, we_d;
  logic [ADDR_W-1:0] saddr_d;
  logic [7:0]        swdata_d;
  logic              misaligned;
  logic [1:0]        idx_nx;
  logic              unused_addr_hi;

  assign misaligned     = (req_size == 2'd2 && req_addr[0]) ||
                          (req_size == 2'd3 && req_addr[1:0] != 2'b00);
  assign idx_nx         = idx_q + 2'd1;
  assign busy           = (state_q != IDLE);
  assign unused_addr_hi = ^(req_addr >> ADDR_W);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    last_d   = last_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    rdata_d  = req_rdata;
    ready_d  = req_ready;
    err_d    = misalign_err;
    re_d     = sram_re;
    we_d     = sram_we;
    saddr_d  = sram_addr;
    swdata_d = sram_wdata;

    case (state_q)
      IDLE: begin
        if (req_size != 2'd0) begin
          base_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          rw_d    = req_rw;
          last_d  = (req_size == 2'd1) ? 2'd0 : (req_size == 2'd2) ? 2'd1 : 2'd3;
          idx_d   = 2'd0;
          wcnt_d  = WS;
          rdata_d = '0;
          if (misaligned) begin
            state_d = ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            saddr_d  = req_addr[ADDR_W-1:0];
            swdata_d = req_wdata[7:0];
            re_d     = !req_rw;
            we_d     = req_rw;
          end
        end
      end
      ACCESS: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          // SRAM data is only valid on the final cycle of each byte access.
          if (!rw_q) rdata_d[{idx_q, 3'b000} +: 8] = sram_rdata;
          if (idx_q == last_q) begin
            state_d = DONE;
            re_d    = 1'b0;
            we_d    = 1'b0;
            ready_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            idx_d    = idx_nx;
            wcnt_d   = WS;
            saddr_d  = base_q + ADDR_W'(idx_nx);
            swdata_d = wdata_q[{idx_nx, 3'b000} +: 8];
          end
        end
      end
      DONE, ERR: begin
        // Wait for withdrawal so a held request is not executed twice.
        if (req_size == 2'd0) begin
          state_d = IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      last_q       <= 2'd0;
      idx_q        <= 2'd0;
      wcnt_q       <= 4'd0;
      req_rdata    <= '0;
      req_ready    <= 1'b0;
      misalign_err <= 1'b0;
      sram_re      <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      req_rdata    <= rdata_d;
      req_ready    <= ready_d;
      misalign_err <= err_d;
      sram_re      <= re_d;
      sram_we      <= we_d;
      sram_addr    <= saddr_d;
      sram_wdata   <= swdata_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Drives two bridges (WAIT_STATES=0 and 1) with identical requests and checks both against a byte-level memory model.
module tb_mem_byte_bridge;

  typedef struct packed {
    logic        inst;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [7:0]  wd;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr, req_wdata;
  logic        req_rw;
  logic [1:0]  req_size;

  logic [31:0] rdata [2];
  logic        rdy [2], bsy [2], err [2], s_re [2], s_we [2];
  logic [15:0] s_addr [2];
  logic [7:0]  s_wd [2], s_rd [2];

  logic [7:0]  smem [2][65536];
  bit          wflag [2][65536];
  int          run [2];
  logic        prev_re [2];
  logic [15:0] prev_addr [2];
  logic [7:0]  ref_mem [int];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_byte_bridge #(.ADDR_W(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata), .req_rw(req_rw),
    .req_size(req_size), .req_rdata(rdata[0]), .req_ready(rdy[0]), .busy(bsy[0]),
    .misalign_err(err[0]), .sram_addr(s_addr[0]), .sram_wdata(s_wd[0]), .sram_rdata(s_rd[0]),
    .sram_re(s_re[0]), .sram_we(s_we[0]));

  mem_byte_bridge #(.ADDR_W(16), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata), .req_rw(req_rw),
    .req_size(req_size), .req_rdata(rdata[1]), .req_ready(rdy[1]), .busy(bsy[1]),
    .misalign_err(err[1]), .sram_addr(s_addr[1]), .sram_wdata(s_wd[1]), .sram_rdata(s_rd[1]),
    .sram_re(s_re[1]), .sram_we(s_we[1]));

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] sram_byte(input int i, input logic [15:0] a);
    return wflag[i][a] ? smem[i][a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  function automatic acc_t mk(input int i, input logic [15:0] a, input logic re, input logic we,
                              input logic [7:0] wd);
    acc_t r;
    r.inst = 1'(i);
    r.addr = a;
    r.re   = re;
    r.we   = we;
    r.wd   = we ? wd : 8'h00;
    return r;
  endfunction

  // SRAM model: writes on the clock; read data is garbage except on the last cycle of an access.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_we[i]) begin
        smem[i][s_addr[i]]  <= s_wd[i];
        wflag[i][s_addr[i]] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      run[i]       <= (s_re[i] && prev_re[i] && s_addr[i] == prev_addr[i]) ? run[i] + 1 : 0;
      prev_re[i]   <= s_re[i];
      prev_addr[i] <= s_addr[i];
    end
  end

  assign s_rd[0] = (run[0] == 0) ? sram_byte(0, s_addr[0]) : ~sram_byte(0, s_addr[0]);
  assign s_rd[1] = (run[1] == 1) ? sram_byte(1, s_addr[1]) : ~sram_byte(1, s_addr[1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic [1:0] sz, input int hold);
    acc_t        tr[$], got[$], exp_tr[$];
    int          n, lat;
    int          rc [2];
    logic        mis;
    logic [31:0] exp_rd;
    logic [15:0] ba;

    n      = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    mis    = (sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'b00);
    exp_rd = '0;
    if (!mis && !rw)
      for (int b = 0; b < n; b++) begin
        ba = a[15:0] + 16'(b);
        exp_rd[8*b +: 8] = ref_rd(ba);
      end

    @(negedge clk);
    req_addr = a; req_wdata = wd; req_rw = rw; req_size = sz;
    rc = '{-1, -1};
    for (int c = 1; c <= 80 && (rc[0] < 0 || rc[1] < 0); c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_addr = $urandom; req_wdata = $urandom; req_rw = 1'($urandom);
      end
      for (int i = 0; i < 2; i++) begin
        if (s_re[i] || s_we[i]) tr.push_back(mk(i, s_addr[i], s_re[i], s_we[i], s_wd[i]));
        if (rdy[i] && rc[i] < 0) rc[i] = c;
      end
    end
    repeat (hold) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (s_re[i] || s_we[i]) tr.push_back(mk(i, s_addr[i], s_re[i], s_we[i], s_wd[i]));
    end

    for (int i = 0; i < 2; i++) begin
      lat = mis ? 1 : 1 + n * (i + 1);
      chk($sformatf("%s.u%0d.latency", name, i), 32'(rc[i]), 32'(lat));
      chk($sformatf("%s.u%0d.ready_held", name, i), 32'(rdy[i]), 32'd1);
      chk($sformatf("%s.u%0d.misalign", name, i), 32'(err[i]), 32'(mis));
      chk($sformatf("%s.u%0d.rdata", name, i), rdata[i], exp_rd);
      exp_tr.delete();
      got.delete();
      if (!mis)
        for (int b = 0; b < n; b++)
          for (int k = 0; k <= i; k++) begin
            ba = a[15:0] + 16'(b);
            exp_tr.push_back(mk(i, ba, !rw, rw, wd[8*b +: 8]));
          end
      foreach (tr[j]) if (tr[j].inst == 1'(i)) got.push_back(tr[j]);
      chk($sformatf("%s.u%0d.strobe_cycles", name, i), 32'(got.size()), 32'(exp_tr.size()));
      for (int j = 0; j < got.size() && j < exp_tr.size(); j++)
        chk($sformatf("%s.u%0d.access%0d", name, i, j), 32'(got[j]), 32'(exp_tr[j]));
    end

    @(negedge clk);
    req_size = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.busy_after_drop", name, i), 32'(bsy[i]), 32'd0);
      chk($sformatf("%s.u%0d.ready_after_drop", name, i), 32'(rdy[i]), 32'd0);
    end
    if (!mis && rw)
      for (int b = 0; b < n; b++) begin
        ba = a[15:0] + 16'(b);
        ref_mem[int'(ba)] = wd[8*b +: 8];
      end
  endtask

  task automatic chk_idle(input string name);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.rdata", name, i), rdata[i], 32'd0);
      chk($sformatf("%s.u%0d.ready", name, i), 32'(rdy[i]), 32'd0);
      chk($sformatf("%s.u%0d.busy", name, i), 32'(bsy[i]), 32'd0);
      chk($sformatf("%s.u%0d.misalign", name, i), 32'(err[i]), 32'd0);
      chk($sformatf("%s.u%0d.sram_addr", name, i), 32'(s_addr[i]), 32'd0);
      chk($sformatf("%s.u%0d.sram_wdata", name, i), 32'(s_wd[i]), 32'd0);
      chk($sformatf("%s.u%0d.sram_re", name, i), 32'(s_re[i]), 32'd0);
      chk($sformatf("%s.u%0d.sram_we", name, i), 32'(s_we[i]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b0; req_addr = '0; req_wdata = '0; req_rw = 1'b0; req_size = 2'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;

    run_req("setup_wr", 32'h0000_0100, 32'h1234_5678, 1'b1, 2'd3, 0);
    run_req("word_rd", 32'h0000_0100, 32'h0, 1'b0, 2'd3, 0);
    chk("word_rd.u1.value", rdata[1], 32'h1234_5678);
    run_req("half_wr", 32'h0000_0022, 32'hAABB_CCDD, 1'b1, 2'd2, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("half_wr.u%0d.byte22", i), 32'(sram_byte(i, 16'h0022)), 32'h0000_00DD);
      chk($sformatf("half_wr.u%0d.byte24_untouched", i), 32'(sram_byte(i, 16'h0024)),
          32'(init_byte(16'h0024)));
    end
    run_req("mis_word", 32'h0000_0102, 32'h0, 1'b0, 2'd3, 0);
    run_req("mis_half", 32'h0000_0041, 32'hFFFF_FFFF, 1'b1, 2'd2, 0);
    run_req("held_byte", 32'h0000_0040, 32'h0, 1'b0, 2'd1, 20);
    run_req("after_held", 32'h0000_0041, 32'h0, 1'b0, 2'd1, 0);
    run_req("wrap_word", 32'h0001_FFFC, 32'h0, 1'b0, 2'd3, 0);
    run_req("wrap_byte", 32'h0000_FFFF, 32'h0, 1'b0, 2'd1, 0);

    // Abort a word write part-way; the rewrite to the same address restores a consistent memory.
    @(negedge clk);
    req_addr = 32'h0000_0200; req_wdata = 32'hCAFE_F00D; req_rw = 1'b1; req_size = 2'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0; req_size = 2'd0;
    @(negedge clk);
    chk_idle("mid_reset");
    rst = 1'b1;
    run_req("post_rst_wr", 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 2'd3, 0);
    run_req("post_rst_rd", 32'h0000_0200, 32'h0, 1'b0, 2'd3, 0);

    for (int k = 0; k < 40; k++) begin
      sz = 2'($urandom_range(1, 3));
      a  = $urandom;
      a[15:6] = 10'h00C;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[0] = 1'b0;
        if (sz == 2'd3) a[1:0] = 2'b00;
      end
      run_req($sformatf("rnd%0d", k), a, $urandom, 1'($urandom), sz, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
